// File: rtl/isa_io_target.sv
// ---------------------------------------------------------------------------
// isa_io_target
//
// ISA 8-bit I/O responder. This module decodes a 4-register window at
// BASE_ADDR and answers IOR/IOW cycles from the host.
//   off 0 DATA    : a write pushes the TX FIFO; a read pops the RX FIFO
//                   (0xFF and RX_UNF when the FIFO is empty)
//   off 1 STATUS  : {0,0,txe,IRQ,RX_UNF,TX_OVF,TX full,RX not empty};
//                   writing 1 to bit2 or bit3 clears that flag
//   off 2 CONTROL : bit0 RX_IRQ_EN (bit1 TX_EMPTY_IRQ_EN when enabled)
//   off 3 SCRATCH : 8-bit read/write
//
// Optional feature macro: SUPERIO_TX_EMPTY_IRQ_EN
//   When it is defined, CONTROL bit1 enables an IRQ term on TX empty and
//   STATUS bit5 reports TX empty. When it is undefined, both bits read 0.
//
// Ports
//   clk           system clock (50 MHz)
//   global_reset  asynchronous active-low reset, released synchronously
//   A[15:0]       ISA address
//   D[7:0]        ISA data (inout). Driven only while a read is in progress.
//   IOR, IOW      ISA read/write strobes, active low, asynchronous
//   AEN           DMA address enable; cycles are ignored while it is high
//   IRQ           registered interrupt request, active high
//   tx_data/tx_valid/tx_ready  host->local FIFO read port
//   rx_data/rx_valid/rx_ready  local->host FIFO write port
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module isa_io_target #(
  parameter logic [15:0] BASE_ADDR = 16'h0220,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        global_reset,
  input  logic [15:0] A,
  inout  wire  [7:0]  D,
  input  logic        IOR,
  input  logic        IOW,
  input  logic        AEN,
  output logic        IRQ,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_ONE = 1;
  localparam logic [RX_AW:0] RX_ONE = 1;

  function automatic logic [7:0] pack_status(input logic rx_ne, input logic txf,
                                             input logic ovf, input logic unf,
                                             input logic irq, input logic txe);
    logic [7:0] s;
    s = {2'b00, txe, irq, unf, ovf, txf, rx_ne};
    return s;
  endfunction

  // Reset synchroniser: assertion is immediate, release is aligned to clk.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge global_reset) begin
    if (!global_reset) rst_sync <= 2'b00;
    else               rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // ---- strobe synchronisers: p0/p1 metastability, p2 edge detect ----
  // The flops reset to 0 ("asserted"), so a strobe that is still low when
  // reset releases shows no falling edge until it goes high and low again.
  logic ior_p0, ior_p1, ior_p2;
  logic iow_p0, iow_p1, iow_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ior_p0 <= 1'b0;
      ior_p1 <= 1'b0;
      ior_p2 <= 1'b0;
      iow_p0 <= 1'b0;
      iow_p1 <= 1'b0;
      iow_p2 <= 1'b0;
    end else begin
      ior_p0 <= IOR;
      ior_p1 <= ior_p0;
      ior_p2 <= ior_p1;
      iow_p0 <= IOW;
      iow_p1 <= iow_p0;
      iow_p2 <= iow_p1;
    end
  end

  // ---- decode (edge cycle) ----
  logic       hit;
  logic [1:0] off;
  logic       rd_start;
  logic       wr_start;

  assign hit = (A[15:2] == BASE_ADDR[15:2]) && !AEN;
  assign off = A[1:0];
  // Requiring the other strobe to be high blocks any overlapped IOR/IOW.
  assign rd_start = ior_p2 && !ior_p1 && iow_p1 && hit;
  assign wr_start = iow_p2 && !iow_p1 && ior_p1 && hit;

  // ---- TX FIFO (host -> local) ----
  logic [TX_AW:0] tx_wr_ptr;
  logic [TX_AW:0] tx_rd_ptr;
  logic [7:0]     tx_mem [TX_DEPTH];
  logic           tx_full;
  logic           tx_empty;
  logic           tx_push;
  logic           tx_pop;

  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                    (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
  assign tx_push  = wr_start && (off == 2'd0) && !tx_full;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rd_ptr[TX_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= D;
  end

  // ---- RX FIFO (local -> host) ----
  logic [RX_AW:0] rx_wr_ptr;
  logic [RX_AW:0] rx_rd_ptr;
  logic [7:0]     rx_mem [RX_DEPTH];
  logic           rx_full;
  logic           rx_empty;
  logic           rx_push;
  logic           rx_pop;
  logic [7:0]     rx_head;

  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                    (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_start && (off == 2'd0) && !rx_empty;
  assign rx_head  = rx_mem[rx_rd_ptr[RX_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_data;
  end

  // ---- register file ----
  logic       rx_irq_en;
  logic       tx_ovf;
  logic       rx_unf;
  logic [7:0] scratch;
  logic       txe_irq_term;
  logic       status_txe;
  logic [7:0] ctrl_rd;

`ifdef SUPERIO_TX_EMPTY_IRQ_EN
  logic tx_empty_irq_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         tx_empty_irq_en <= 1'b0;
    else if (wr_start && off == 2'd2)   tx_empty_irq_en <= D[1];
  end

  assign txe_irq_term = tx_empty_irq_en && tx_empty;
  assign status_txe   = tx_empty;
  assign ctrl_rd      = {6'b0, tx_empty_irq_en, rx_irq_en};
`else
  assign txe_irq_term = 1'b0;
  assign status_txe   = 1'b0;
  assign ctrl_rd      = {7'b0, rx_irq_en};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_irq_en <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_unf    <= 1'b0;
      scratch   <= 8'h00;
    end else begin
      if (wr_start) begin
        case (off)
          2'd0: if (tx_full) tx_ovf <= 1'b1;
          2'd1: begin
            if (D[2]) tx_ovf <= 1'b0;
            if (D[3]) rx_unf <= 1'b0;
          end
          2'd2: rx_irq_en <= D[0];
          default: scratch <= D;
        endcase
      end
      if (rd_start && (off == 2'd0) && rx_empty) rx_unf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) IRQ <= 1'b0;
    else        IRQ <= (rx_irq_en && !rx_empty) || txe_irq_term;
  end

  // ---- read path: value captured in the edge cycle, driven next cycle ----
  logic [7:0] rd_val;
  logic [7:0] rd_reg;
  logic       d_oe;

  always_comb begin
    rd_val = 8'h00;
    case (off)
      2'd0:    rd_val = rx_empty ? 8'hFF : rx_head;
      2'd1:    rd_val = pack_status(!rx_empty, tx_full, tx_ovf, rx_unf, IRQ, status_txe);
      2'd2:    rd_val = ctrl_rd;
      default: rd_val = scratch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rd_start) rd_reg <= rd_val;
  end

  // Drop the bus once IOR is seen high again, or as soon as IOW joins in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  d_oe <= 1'b0;
    else if (rd_start)           d_oe <= 1'b1;
    else if (ior_p1 || !iow_p1)  d_oe <= 1'b0;
  end

  assign D = d_oe ? rd_reg : 8'hzz;

endmodule

// File: tb/tb_isa_io_target.sv
`timescale 1ns/1ps
module tb_isa_io_target;

`ifdef SUPERIO_TX_EMPTY_IRQ_EN
  localparam logic [7:0] TXE = 8'h20;
`else
  localparam logic [7:0] TXE = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        global_reset;
  logic [15:0] A;
  logic        IOR, IOW, AEN;
  logic        IRQ;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  drv_val;
  logic        drv_en;
  tri1  [7:0]  D_bus;

  assign D_bus = drv_en ? drv_val : 8'hzz;

  always #10 clk = ~clk;

  isa_io_target dut (
    .clk          (clk),
    .global_reset (global_reset),
    .A            (A),
    .D            (D_bus),
    .IOR          (IOR),
    .IOW          (IOW),
    .AEN          (AEN),
    .IRQ          (IRQ),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic isa_write(input logic [15:0] addr, input logic [7:0] val, input logic aen);
    @(posedge clk); #1;
    A = addr; AEN = aen; drv_val = val; drv_en = 1'b1;
    @(posedge clk); #1;
    IOW = 1'b0;
    repeat (4) @(posedge clk);
    #1 IOW = 1'b1;
    repeat (3) @(posedge clk);
    #1 drv_en = 1'b0; AEN = 1'b0;
  endtask

  // data: D sampled exactly 4 clk after IOR falls; rel: D 4 clk after IOR rises.
  task automatic isa_read(input logic [15:0] addr, input logic push_en, input logic [7:0] push_val,
                          output logic [7:0] data, output logic [7:0] rel);
    @(posedge clk); #1;
    A = addr;
    @(posedge clk); #1;
    IOR = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (push_en) begin
      rx_data = push_val;
      rx_valid = 1'b1;
    end
    @(posedge clk); #1 rx_valid = 1'b0;
    @(posedge clk); #1 data = D_bus;
    IOR = 1'b1;
    repeat (4) @(posedge clk);
    #1 rel = D_bus;
  endtask

  task automatic rx_push(input logic [7:0] v);
    @(negedge clk);
    rx_data = v;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd, rel, v, e;
    logic [7:0] q[$];

    global_reset = 1'b1; IOR = 1'b1; IOW = 1'b1; AEN = 1'b0; A = 16'h0000;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; drv_val = 8'h00; drv_en = 1'b0;
    #5 global_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_d_hiz", D_bus, 8'hFF);
    check_vec("rst_irq", {7'b0, IRQ}, 8'h00);
    check_vec("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    check_vec("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    global_reset = 1'b1;
    repeat (5) @(posedge clk);

    isa_read(16'h0221, 1'b0, 8'h00, rd, rel);
    check_vec("rst_status", rd, TXE);
    isa_read(16'h0222, 1'b0, 8'h00, rd, rel);
    check_vec("rst_control", rd, 8'h00);
    isa_read(16'h0223, 1'b0, 8'h00, rd, rel);
    check_vec("rst_scratch", rd, 8'h00);

    // Scratch round trip
    isa_write(16'h0223, 8'h5A, 1'b0);
    isa_read(16'h0223, 1'b0, 8'h00, rd, rel);
    check_vec("scratch_rd", rd, 8'h5A);
    check_vec("scratch_release", rel, 8'hFF);

    // TX path: fill, overflow, drain, clear
    for (int i = 1; i <= 9; i++) isa_write(16'h0220, 8'(i), 1'b0);
    check_vec("tx_valid_full", {7'b0, tx_valid}, 8'h01);
    isa_read(16'h0221, 1'b0, 8'h00, rd, rel);
    check_vec("tx_full_status", rd, 8'h06);
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check_vec("tx_drain_valid", {7'b0, tx_valid}, 8'h01);
      check_vec("tx_drain_data", tx_data, 8'(i));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check_vec("tx_empty_after", {7'b0, tx_valid}, 8'h00);
    isa_write(16'h0221, 8'h04, 1'b0);
    isa_read(16'h0221, 1'b0, 8'h00, rd, rel);
    check_vec("tx_ovf_clear", rd, TXE);

    // Decode filter
    isa_write(16'h0224, 8'h77, 1'b0);
    isa_write(16'h0220, 8'h66, 1'b1);
    isa_write(16'h0223, 8'h11, 1'b1);
    #1;
    check_vec("dec_tx_untouched", {7'b0, tx_valid}, 8'h00);
    isa_read(16'h0223, 1'b0, 8'h00, rd, rel);
    check_vec("dec_scratch_kept", rd, 8'h5A);
    isa_read(16'h0224, 1'b0, 8'h00, rd, rel);
    check_vec("dec_miss_hiz", rd, 8'hFF);

    // RX path and IRQ
    isa_write(16'h0222, 8'hFD, 1'b0);
    isa_read(16'h0222, 1'b0, 8'h00, rd, rel);
    check_vec("ctrl_rd", rd, 8'h01);
    check_vec("irq_idle", {7'b0, IRQ}, 8'h00);
    rx_push(8'hA1);
    rx_push(8'hB2);
    repeat (2) @(posedge clk);
    #1 check_vec("irq_set", {7'b0, IRQ}, 8'h01);
    isa_read(16'h0220, 1'b0, 8'h00, rd, rel);
    check_vec("rx_pop1", rd, 8'hA1);
    check_vec("irq_hold", {7'b0, IRQ}, 8'h01);
    isa_read(16'h0220, 1'b0, 8'h00, rd, rel);
    check_vec("rx_pop2", rd, 8'hB2);
    check_vec("irq_drop", {7'b0, IRQ}, 8'h00);
    isa_read(16'h0220, 1'b0, 8'h00, rd, rel);
    check_vec("rx_underflow_data", rd, 8'hFF);
    isa_read(16'h0221, 1'b0, 8'h00, rd, rel);
    check_vec("rx_unf_status", rd, 8'h08 | TXE);
    isa_write(16'h0221, 8'h08, 1'b0);
    isa_read(16'h0221, 1'b0, 8'h00, rd, rel);
    check_vec("rx_unf_clear", rd, TXE);

    // Wrap and concurrency on RX
    for (int i = 0; i < 8; i++) begin
      v = 8'h40 + 8'(i * 3);
      rx_push(v);
      q.push_back(v);
    end
    @(negedge clk);
    check_vec("rx_full_ready", {7'b0, rx_ready}, 8'h00);
    rx_push(8'hEE);
    isa_read(16'h0220, 1'b0, 8'h00, rd, rel);
    e = q.pop_front();
    check_vec("wrap_first_pop", rd, e);
    check_vec("wrap_ready_back", {7'b0, rx_ready}, 8'h01);
    for (int i = 8; i < 20; i++) begin
      v = 8'h40 + 8'(i * 3);
      isa_read(16'h0220, 1'b1, v, rd, rel);
      e = q.pop_front();
      q.push_back(v);
      check_vec("wrap_concurrent_pop", rd, e);
      check_vec("wrap_concurrent_ready", {7'b0, rx_ready}, {7'b0, (q.size() < 8)});
    end
    while (q.size() > 0) begin
      isa_read(16'h0220, 1'b0, 8'h00, rd, rel);
      e = q.pop_front();
      check_vec("wrap_drain_pop", rd, e);
    end
    isa_read(16'h0221, 1'b0, 8'h00, rd, rel);
    check_vec("wrap_final_status", rd, TXE);

    // Reset in the middle of a read
    rx_push(8'h99);
    @(posedge clk); #1 A = 16'h0220;
    @(posedge clk); #1 IOR = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_vec("midrst_driven", D_bus, 8'h99);
    #3 global_reset = 1'b0;
    #1 check_vec("midrst_release", D_bus, 8'hFF);
    check_vec("midrst_irq", {7'b0, IRQ}, 8'h00);
    repeat (3) @(posedge clk);
    #1 global_reset = 1'b1;
    repeat (6) @(posedge clk);
    #1 check_vec("midrst_held_hiz", D_bus, 8'hFF);
    IOR = 1'b1;
    repeat (4) @(posedge clk);
    isa_read(16'h0221, 1'b0, 8'h00, rd, rel);
    check_vec("midrst_no_action", rd, TXE);
    isa_read(16'h0223, 1'b0, 8'h00, rd, rel);
    check_vec("midrst_scratch", rd, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/isa_io_target.md
Name: isa_io_target

Overview:
- ISA 8-bit I/O responder: the device-side counterpart of the host bus initiator that drives A/D/IOR/IOW.
- Decodes a 4-register window at BASE_ADDR and responds to IOR/IOW cycles.
- Bridges host writes into a TX FIFO (toward local logic) and local data from an RX FIFO to host reads.
- Raises IRQ when RX data is pending; used to model and bring up the riser card-side endpoint.

Parameters:
- BASE_ADDR, 16'h0220, I/O window base; bits [1:0] ignored.
- TX_DEPTH, 8, host→local FIFO entries (power of 2, ≥2).
- RX_DEPTH, 8, local→host FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock (50 MHz).
- global_reset  input  1  asynchronous, active-low reset.
- A  input  16  ISA address.
- D  inout  8  ISA data; driven only while D_oe is high, else high-Z.
- IOR  input  1  ISA read strobe, active low, asynchronous.
- IOW  input  1  ISA write strobe, active low, asynchronous.
- AEN  input  1  DMA address enable; cycles are ignored while high.
- IRQ  output  1  interrupt request, active high, registered.
- tx_data  output  8  FIFO head toward local logic.
- tx_valid  output  1  TX FIFO not empty.
- tx_ready  input  1  local pop; transfer occurs when tx_valid&tx_ready.
- rx_data  input  8  local data toward host.
- rx_valid  input  1  local push request.
- rx_ready  output  1  RX FIFO not full.

Behaviour:
- Reset (async assert, sync release):
  - D high-Z; IRQ=0; tx_valid=0; rx_ready=1.
  - Both FIFOs empty; CONTROL=0x00; SCRATCH=0x00; sticky flags=0.
- Synchronisation:
  - IOR and IOW each pass through 2 flops, plus a 3rd flop for edge detect.
  - A falling edge of a synced strobe is a cycle start.
- Decode:
  - hit = (A[15:2]==BASE_ADDR[15:2]) & ~AEN, sampled in the edge cycle.
  - off = A[1:0].
- Write: on synced IOW falling edge with hit, latch D and perform the register action in that same cycle. Exactly one action per strobe.
- Read:
  - On synced IOR falling edge with hit, latch the read value into the output register and set D_oe=1 on the next cycle.
  - D_oe falls on the cycle after synced IOR returns high.
  - Latency from pin IOR low to D valid is ≤4 clk. Pop side effects occur once per strobe.
- Registers:
  - off 0 DATA:
    - Write pushes TX; if TX full, data is dropped and TX_OVF is set.
    - Read pops RX; if RX empty, returns 0xFF and sets RX_UNF.
  - off 1 STATUS (read):
    - bit0 RX not empty, bit1 TX full, bit2 TX_OVF, bit3 RX_UNF, bit4 IRQ, bits[7:5]=0.
    - Write 1 to clear bits 2 and 3; other bits ignore writes.
  - off 2 CONTROL: R/W; bit0 RX_IRQ_EN; unused bits read 0.
  - off 3 SCRATCH: R/W, 8 bits.
- FIFOs:
  - Pointer width clog2(DEPTH)+1; pointers wrap naturally.
  - Full = MSB differs and the rest equal; empty = pointers equal.
  - TX read port: tx_data shows the head combinationally from storage.
  - Simultaneous push and pop on the same FIFO in one cycle are both honoured; count is unchanged.
  - Push when full is ignored on the local side (rx_ready=0). Pop when empty is ignored.
- IRQ: registered, equal to RX_IRQ_EN & RX not empty (plus the optional term below). Updates 1 clk after its cause.
- Overlap: if IOR and IOW are both asserted, no action is taken and D stays high-Z.
- Reset mid-cycle: D is released immediately; a strobe that is still low after reset release produces no action until it deasserts and reasserts.

Optional Feature:
- Macro: SUPERIO_TX_EMPTY_IRQ_EN.
- Defined:
  - CONTROL bit1 = TX_EMPTY_IRQ_EN.
  - STATUS bit5 = TX empty.
  - IRQ additionally asserts when TX_EMPTY_IRQ_EN & TX empty.
- Undefined: CONTROL bit1 and STATUS bit5 read 0, and IRQ has no TX term.

Test Plan:
- Scratch: IOW to 0x223 with 0x5A, then IOR 0x223 → D=0x5A, D_oe high ≤4 clk after IOR low; D high-Z after IOR high.
- TX path: with tx_ready=0, 9 IOW writes to 0x220 (values 1..9) → tx_valid=1, STATUS reads 0x06 (TX full, TX_OVF). Set tx_ready=1 → values 1..8 drain in order. Write 0x04 to 0x221 → TX_OVF clears.
- RX path and IRQ: CONTROL=0x01, local pushes 0xA1,0xB2 → IRQ=1. Reads of 0x220 return 0xA1 then 0xB2; IRQ drops after the second pop. A third read returns 0xFF and STATUS bit3=1.
- Decode filter: IOW to 0x224, and IOW to 0x220 with AEN=1 → no FIFO or register change; IOR to 0x224 → D stays high-Z.
- Wrap and concurrency: 20 interleaved local pushes and host pops on RX with simultaneous push/pop cycles → data order preserved and no spurious full/empty.
- Reset mid-read: assert global_reset while IOR is low and D is driven → D high-Z at once. IOR held low through reset release → no pop.
